// File: rtl/data_mem_sram_responder_if.sv
// MEM-stage data-memory request/response bundle between MEM_Stage (master)
// and the SRAM responder (slave).
interface data_mem_sram_responder_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] Address;
    logic [31:0] ST_val;
    logic [31:0] MEM_read_value;
    logic        Ready;
    logic        Freeze;

    modport master (
        output MEM_R_EN, MEM_W_EN, Address, ST_val,
        input  MEM_read_value, Ready, Freeze
    );
    modport slave (
        input  MEM_R_EN, MEM_W_EN, Address, ST_val,
        output MEM_read_value, Ready, Freeze
    );
endinterface

// File: rtl/data_mem_sram_responder.sv
// Word-wide MEM-stage data memory on a 16-bit external SRAM: two half-word
// accesses per word, pipeline frozen until done. Define MEM_ALIGN_CHECK_EN to
// reject misaligned addresses and expose the sticky Misaligned flag.
module data_mem_sram_responder #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    data_mem_sram_responder_if.slave   mem,
    output logic [SRAM_AW-1:0]         SRAM_ADDR,
    output logic [15:0]                SRAM_WDATA,
    input  logic [15:0]                SRAM_RDATA,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_OE_N
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                       Misaligned
`endif
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

    state_t             state, state_nx;
    logic [3:0]         cnt, cnt_nx;
    logic               req, misal, phase_end;
    logic               is_wr, wr_sel, hi_nx, act_nx;
    logic [31:0]        offs, st_q, st_sel;
    logic [SRAM_AW-2:0] word_q, word_sel;
    logic [15:0]        rd_lo;
    logic [SRAM_AW-1:0] addr_nx;
    logic [15:0]        wdata_nx;
    logic               we_n_nx, oe_n_nx;
    logic               unused_offs;

    assign req       = mem.MEM_R_EN | mem.MEM_W_EN;
    assign offs      = mem.Address - 32'(BASE_ADDR);
    assign phase_end = (cnt == LAST);
    // word index wraps silently; byte lane bits and overflow are dropped
    assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};
`ifdef MEM_ALIGN_CHECK_EN
    assign misal = (mem.Address[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            IDLE: if (req) state_nx = misal ? DONE : LO;
            LO:   if (phase_end) state_nx = HI;   else cnt_nx = cnt + 4'd1;
            HI:   if (phase_end) state_nx = DONE; else cnt_nx = cnt + 4'd1;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // SRAM pins are registered from the next state so they hold steady for a whole phase
    assign wr_sel   = (state == IDLE) ? mem.MEM_W_EN     : is_wr;
    assign word_sel = (state == IDLE) ? offs[SRAM_AW:2]  : word_q;
    assign st_sel   = (state == IDLE) ? mem.ST_val       : st_q;
    assign hi_nx    = (state_nx == HI);
    assign act_nx   = (state_nx == LO) || (state_nx == HI);

    always_comb begin
        addr_nx  = '0;
        wdata_nx = '0;
        we_n_nx  = 1'b1;
        oe_n_nx  = 1'b1;
        if (act_nx) begin
            addr_nx = {word_sel, hi_nx};
            we_n_nx = ~wr_sel;
            oe_n_nx = wr_sel;
            if (wr_sel) wdata_nx = hi_nx ? st_sel[31:16] : st_sel[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr              <= 1'b0;
            word_q             <= '0;
            st_q               <= '0;
            rd_lo              <= '0;
            mem.MEM_read_value <= '0;
            SRAM_ADDR          <= '0;
            SRAM_WDATA         <= '0;
            SRAM_WE_N          <= 1'b1;
            SRAM_OE_N          <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            Misaligned         <= 1'b0;
`endif
        end else begin
            SRAM_ADDR  <= addr_nx;
            SRAM_WDATA <= wdata_nx;
            SRAM_WE_N  <= we_n_nx;
            SRAM_OE_N  <= oe_n_nx;
            if (state == IDLE && req) begin
                is_wr  <= mem.MEM_W_EN;
                word_q <= word_sel;
                st_q   <= mem.ST_val;
            end
            if (state == LO && phase_end && !is_wr) rd_lo <= SRAM_RDATA;
            if (state == HI && phase_end && !is_wr) mem.MEM_read_value <= {SRAM_RDATA, rd_lo};
`ifdef MEM_ALIGN_CHECK_EN
            if (state == IDLE && req && misal) Misaligned <= 1'b1;
`endif
        end
    end

    assign mem.Ready  = (state == DONE);
    // gated by reset so the stall drops immediately when an access is abandoned
    assign mem.Freeze = rst_n & req & (state != DONE);
endmodule
